// File: rtl/motor_pkg.sv
// Shared definitions for single-actuator schedulers: FSM state encoding,
// direction constants and the limit-switch helper.
package motor_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_COOL  = 2'd2,
    SCHED_FAULT = 2'd3
  } sched_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Limit switch that terminates a move in the given direction.
  function automatic logic limit_hit(input logic dir, input logic up_lim, input logic dn_lim);
    return (dir == DIR_UP) ? up_lim : dn_lim;
  endfunction

endpackage

// File: rtl/motor_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1,
// searching with wrap-around.
module motor_rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  always_comb begin
    valid   = 1'b0;
    win     = '0;
    win_idx = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      automatic logic [PW-1:0] idx = PW'((32'(ptr) + off) % NREQ);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        win[idx]   = 1'b1;
        win_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/motor_sched.sv
// Round-robin scheduler sharing one reversible motor between NREQ requesters,
// with run timeout, post-move cool-down and latched sensor/timeout fault.
module motor_sched
  import motor_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned COOLDOWN = 8,
  parameter int unsigned CW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_dir,
  input  logic            up_limit,
  input  logic            dn_limit,
  input  logic            clr_fault,
  output logic [NREQ-1:0] gnt,
  output logic            done,
  output logic            done_ok,
  output logic            motor_up,
  output logic            motor_dn,
  output logic            busy,
  output logic            fault
);

  localparam int unsigned PW = $clog2(NREQ);

  sched_state_t    r_state;
  logic [CW-1:0]   r_timer;
  logic [PW-1:0]   r_ptr;
  logic            r_dir;
  logic [NREQ-1:0] r_gnt;
  logic            r_done;
  logic            r_done_ok;
  logic            r_mup;
  logic            r_mdn;
  logic            r_busy;
  logic            r_fault;

  logic            w_valid;
  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_win_idx;
  logic            w_win_dir;
  logic            w_win_hit;
  logic            w_sensor_bad;
  logic            w_req_held;

  motor_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .valid   (w_valid),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  assign w_win_dir    = |(req_dir & w_win);
  assign w_win_hit    = limit_hit(w_win_dir, up_limit, dn_limit);
  assign w_sensor_bad = up_limit & dn_limit;
  assign w_req_held   = |(req & r_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SCHED_IDLE;
      r_timer   <= '0;
      r_ptr     <= PW'(NREQ - 1);
      r_dir     <= DIR_DN;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_done_ok <= 1'b0;
      r_mup     <= 1'b0;
      r_mdn     <= 1'b0;
      r_busy    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_done_ok <= 1'b0;
      // Contradictory limit switches override every other transition.
      if (w_sensor_bad && (r_state != SCHED_FAULT)) begin
        r_state <= SCHED_FAULT;
        r_gnt   <= '0;
        r_mup   <= 1'b0;
        r_mdn   <= 1'b0;
        r_busy  <= 1'b1;
        r_fault <= 1'b1;
        r_done  <= (r_state == SCHED_RUN);
      end else begin
        unique case (r_state)
          SCHED_IDLE: begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
            if (w_valid) begin
              r_gnt <= w_win;
              r_ptr <= w_win_idx;
              r_dir <= w_win_dir;
              if (w_win_hit) begin
                // Already at the target: grant and finish in the same cycle.
                r_done    <= 1'b1;
                r_done_ok <= 1'b1;
              end else begin
                r_state <= SCHED_RUN;
                r_busy  <= 1'b1;
                r_timer <= '0;
                r_mup   <= (w_win_dir == DIR_UP);
                r_mdn   <= (w_win_dir == DIR_DN);
              end
            end
          end
          SCHED_RUN: begin
            if (limit_hit(r_dir, up_limit, dn_limit) || !w_req_held) begin
              r_mup     <= 1'b0;
              r_mdn     <= 1'b0;
              r_gnt     <= '0;
              r_done    <= 1'b1;
              r_done_ok <= limit_hit(r_dir, up_limit, dn_limit);
              r_state   <= SCHED_COOL;
              r_timer   <= '0;
            end else if (r_timer == CW'(TIMEOUT - 1)) begin
              r_mup   <= 1'b0;
              r_mdn   <= 1'b0;
              r_gnt   <= '0;
              r_done  <= 1'b1;
              r_fault <= 1'b1;
              r_state <= SCHED_FAULT;
            end else begin
              r_timer <= r_timer + CW'(1);
            end
          end
          SCHED_COOL: begin
            if (r_timer == CW'(COOLDOWN - 1)) begin
              r_state <= SCHED_IDLE;
              r_busy  <= 1'b0;
              r_timer <= '0;
            end else begin
              r_timer <= r_timer + CW'(1);
            end
          end
          SCHED_FAULT: begin
            r_gnt <= '0;
            r_mup <= 1'b0;
            r_mdn <= 1'b0;
            if (clr_fault && !w_sensor_bad) begin
              r_state <= SCHED_IDLE;
              r_fault <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign done_ok  = r_done_ok;
  assign motor_up = r_mup;
  assign motor_dn = r_mdn;
  assign busy     = r_busy;
  assign fault    = r_fault;

endmodule

// File: tb/tb_motor_sched.sv
// Bench for motor_sched: hand sequences for reset, at-limit, timeout, sensor
// fault and reset mid-run, then a table of moves checked through a scoreboard.
module tb_motor_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req_dir = '0;
  logic       up_limit = 1'b0;
  logic       dn_limit = 1'b0;
  logic       clr_fault = 1'b0;
  logic [3:0] gnt;
  logic       done, done_ok, motor_up, motor_dn, busy, fault;

  motor_sched #(.NREQ(4), .TIMEOUT(50), .COOLDOWN(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir(req_dir),
    .up_limit(up_limit), .dn_limit(dn_limit), .clr_fault(clr_fault),
    .gnt(gnt), .done(done), .done_ok(done_ok),
    .motor_up(motor_up), .motor_dn(motor_dn), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] gnt;
    logic       ok;
    int         up;
    int         dn;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_prev = '0;
  logic [3:0] m_last = '0;
  int         m_up = 0;
  int         m_dn = 0;

  // Monitor: counts motor cycles per grant and checks each move on its done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (gnt != 4'b0 && m_prev == 4'b0) begin
      m_up   = 0;
      m_dn   = 0;
      m_last = gnt;
    end
    if (motor_up) m_up++;
    if (motor_dn) m_dn++;
    chk("motor_exclusive", int'(motor_up & motor_dn), 0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        e = sb.pop_front();
        chk("sb_gnt", int'(m_last), int'(e.gnt));
        chk("sb_done_ok", int'(done_ok), int'(e.ok));
        chk("sb_up_cycles", m_up, e.up);
        chk("sb_dn_cycles", m_dn, e.dn);
      end
    end
    m_prev = gnt;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < maxc);
    #1;
    chk("gnt_seen", int'(gnt != 4'b0), 1);
  endtask

  task automatic wait_done(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < maxc);
    #1;
    chk("done_seen", int'(done), 1);
  endtask

  task automatic cool_wait(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    #1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] dir;
    logic [3:0] gnt;
    int         hold;
    bit         drop;
    bit         gap;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   n;
    int   bc;
    logic tdir;

    tbl[0] = '{4'b1011, 4'b1001, 4'b0001, 4, 1'b0, 1'b0};
    tbl[1] = '{4'b1011, 4'b1001, 4'b0010, 6, 1'b0, 1'b1};
    tbl[2] = '{4'b1011, 4'b1001, 4'b1000, 2, 1'b0, 1'b1};
    tbl[3] = '{4'b1011, 4'b1001, 4'b0001, 1, 1'b0, 1'b1};
    tbl[4] = '{4'b1011, 4'b1001, 4'b0010, 7, 1'b0, 1'b1};
    tbl[5] = '{4'b1011, 4'b1001, 4'b1000, 3, 1'b0, 1'b1};
    tbl[6] = '{4'b0001, 4'b0001, 4'b0001, 20, 1'b0, 1'b0};
    tbl[7] = '{4'b0010, 4'b0000, 4'b0010, 5, 1'b1, 1'b0};

    step();
    rst = 1'b0;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_ok", int'(done_ok), 0);
    chk("rst_motor_up", int'(motor_up), 0);
    chk("rst_motor_dn", int'(motor_dn), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);

    // Target already reached: one-cycle grant with done, no motion, no cool-down.
    dn_limit = 1'b1; req = 4'b0100; req_dir = 4'b0000;
    sb.push_back('{4'b0100, 1'b1, 0, 0});
    step();
    chk("atlim_gnt", int'(gnt), 4'b0100);
    chk("atlim_done", int'(done), 1);
    chk("atlim_busy", int'(busy), 0);
    req = 4'b0000; dn_limit = 1'b0;
    step();
    chk("atlim_gnt_clr", int'(gnt), 0);
    chk("atlim_no_cool", int'(busy), 0);

    // Timeout: exactly 50 drive cycles, then latched fault until cleared.
    req = 4'b0100; req_dir = 4'b0100;
    sb.push_back('{4'b0100, 1'b0, 50, 0});
    wait_gnt(5, n);
    chk("grant_latency", n, 1);
    wait_done(80, n);
    chk("timeout_len", n, 50);
    chk("timeout_fault", int'(fault), 1);
    req = 4'b1000; req_dir = 4'b1000;
    repeat (5) begin
      step();
      chk("fault_no_gnt", int'(gnt), 0);
    end
    sb.push_back('{4'b1000, 1'b1, 3, 0});
    clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("clr_fault", int'(fault), 0);
    wait_gnt(5, n);
    chk("post_clr_gnt", int'(gnt), 4'b1000);
    repeat (2) step();
    up_limit = 1'b1;
    wait_done(5, n);
    chk("post_clr_limit_react", n, 1);
    up_limit = 1'b0; req = 4'b0000;
    cool_wait(bc);
    chk("post_clr_cool_len", bc, 8);

    // Both limits during RUN: immediate fault, clr_fault ignored while both high.
    req = 4'b0001; req_dir = 4'b0001;
    sb.push_back('{4'b0001, 1'b0, 3, 0});
    wait_gnt(20, n);
    repeat (2) step();
    up_limit = 1'b1; dn_limit = 1'b1;
    step();
    chk("sensor_fault", int'(fault), 1);
    chk("sensor_gnt", int'(gnt), 0);
    chk("sensor_motor", int'(motor_up | motor_dn), 0);
    chk("sensor_done", int'(done), 1);
    req = 4'b0000; clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("sensor_clr_ignored", int'(fault), 1);
    up_limit = 1'b0; dn_limit = 1'b0; clr_fault = 1'b1;
    step();
    clr_fault = 1'b0;
    chk("sensor_clr", int'(fault), 0);
    chk("sensor_clr_idle", int'(busy), 0);

    // Reset mid-run: all outputs drop next edge, no done, priority back to index 0.
    req = 4'b0010; req_dir = 4'b0000;
    wait_gnt(5, n);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run_outputs", int'({gnt, done, done_ok, motor_up, motor_dn, busy, fault}), 0);
    req = 4'b0000;
    bc = 0;

    for (int i = 0; i < 8; i++) begin
      tdir    = |(tbl[i].dir & tbl[i].gnt);
      req     = tbl[i].req;
      req_dir = tbl[i].dir;
      sb.push_back('{tbl[i].gnt, !tbl[i].drop, tdir ? tbl[i].hold : 0, tdir ? 0 : tbl[i].hold});
      wait_gnt(20, n);
      chk($sformatf("vec%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      if (tbl[i].gap) chk($sformatf("vec%0d_gap_ge9", i), int'((bc + n) >= 9), 1);
      repeat (tbl[i].hold - 1) step();
      if (tbl[i].drop) req = tbl[i].req & ~tbl[i].gnt;
      else if (tdir) up_limit = 1'b1;
      else dn_limit = 1'b1;
      wait_done(5, n);
      chk($sformatf("vec%0d_end_latency", i), n, 1);
      up_limit = 1'b0; dn_limit = 1'b0;
      cool_wait(bc);
      chk($sformatf("vec%0d_cool_len", i), bc, 8);
    end
    req = 4'b0000;
    step();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
